// File: rtl/io_out_buffer.sv
// Output byte FIFO between core and UART transmitter.
// Optional IO_OUT_WORD_EN: push all four out_data bytes per write.
module io_out_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  out_issued,
  input  logic [31:0]           out_data,
  output logic                  out_stall,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef IO_OUT_WORD_EN
  localparam int N = 4;
`else
  localparam int N = 1;
  logic unused_hi;
  assign unused_hi = ^out_data[31:8];
`endif

  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] N_C =
    (DEPTH_LOG2+1)'(N);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   free;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push;
  logic                  pop;

  assign free       = DEPTH_C - count;
  assign out_stall  = out_issued && (free < N_C);
  assign push       = out_issued && !out_stall;
  assign tx_valid   = (count != '0);
  assign pop        = tx_valid && tx_ready;
  assign tx_data    = mem[rd_ptr];
  assign fifo_count = count;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt = count;
    if (push)
      count_nxt = count_nxt + N_C;
    if (pop)
      count_nxt = count_nxt - 1'b1;
  end

  // Storage write; a multi-byte push may wrap.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < N; i++)
        mem[wr_ptr + DEPTH_LOG2'(i)] <=
          out_data[8*i +: 8];
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + DEPTH_LOG2'(N);
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_io_out_buffer.sv
// Directed bench for io_out_buffer with a queue
// reference for the streaming tests.
module tb_io_out_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef IO_OUT_WORD_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [DL:0] fifo_count;

  int         n_err = 0;
  int         n_chk = 0;
  int         rx_cnt = 0;
  logic [7:0] q   [$];
  logic [7:0] rxq [$];
  logic       acc;

  always #5 clk = ~clk;

  io_out_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_issued (out_issued),
    .out_data   (out_data),
    .out_stall  (out_stall),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input  logic        iss,
                           input  logic [31:0] d,
                           input  logic        rdy,
                           output logic        ok);
    logic es;
    out_issued = iss;
    out_data   = d;
    tx_ready   = rdy;
    #1;
    es = iss && ((DEPTH - q.size()) < N);
    chk("m_stall", 32'(out_stall), 32'(es));
    chk("m_valid", 32'(tx_valid),
        32'(q.size() != 0));
    chk("m_count", 32'(fifo_count),
        32'(q.size()));
    if (q.size() != 0)
      chk("m_data", 32'(tx_data), 32'(q[0]));
    ok = iss && !es;
    if (q.size() != 0 && rdy) begin
      rxq.push_back(tx_data);
      void'(q.pop_front());
      rx_cnt++;
    end
    if (ok)
      for (int i = 0; i < N; i++)
        q.push_back(d[8*i +: 8]);
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int k = 0; k < 60 && q.size() != 0; k++)
      run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("drain_empty", 32'(fifo_count), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    out_issued = 1'b1;
    out_data   = 32'h77;
    tx_ready   = 1'b1;
    tick;
    tick;
    chk("rst_stall", 32'(out_stall), 32'h0);
    chk("rst_valid", 32'(tx_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    rst        = 1'b0;
    out_issued = 1'b0;
    tick;
    chk("post_rst_cnt", 32'(fifo_count), 32'h0);
    chk("post_rst_vld", 32'(tx_valid), 32'h0);

`ifndef IO_OUT_WORD_EN
    tx_ready   = 1'b1;
    out_issued = 1'b1;
    out_data   = 32'h000000A5;
    #1;
    chk("t2_stall", 32'(out_stall), 32'h0);
    tick;
    out_issued = 1'b0;
    #1;
    chk("t2_valid", 32'(tx_valid), 32'h1);
    chk("t2_data", 32'(tx_data), 32'hA5);
    chk("t2_count", 32'(fifo_count), 32'h1);
    tick;
    chk("t2_empty", 32'(fifo_count), 32'h0);
    chk("t2_novld", 32'(tx_valid), 32'h0);

    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_issued = 1'b1;
      out_data   = 32'(i) | 32'hABCD_0000;
      tick;
    end
    out_issued = 1'b1;
    out_data   = 32'h10;
    #1;
    chk("t3_count", 32'(fifo_count), 32'd16);
    chk("t3_stall", 32'(out_stall), 32'h1);
    chk("t3_data", 32'(tx_data), 32'h00);
    tick;
    chk("t3_blocked", 32'(fifo_count), 32'd16);
    tx_ready = 1'b1;
    #1;
    chk("t3_nobypass", 32'(out_stall), 32'h1);
    tick;
    tx_ready = 1'b0;
    #1;
    chk("t3_cnt15", 32'(fifo_count), 32'd15);
    chk("t3_unstall", 32'(out_stall), 32'h0);
    chk("t3_next", 32'(tx_data), 32'h01);
    tick;
    out_issued = 1'b0;
    #1;
    chk("t3_refull", 32'(fifo_count), 32'd16);
    for (int k = 1; k <= 16; k++)
      q.push_back(8'(k));

    begin
      int nx;
      nx = 0;
      for (int c = 0; c < 24; c++) begin
        run_cycle(1'b1, 32'(8'h11 + 8'(nx)),
                  1'b1, acc);
        if (acc)
          nx++;
      end
      chk("t4_pushed", 32'(nx), 32'd23);
    end
    out_issued = 1'b0;
    #1;
    chk("t4_count", 32'(fifo_count), 32'd15);
    drain;

    begin
      int sent;
      int cyc;
      logic [1:0] pat;
      sent   = 0;
      cyc    = 0;
      rx_cnt = 0;
      while ((sent < 100 || q.size() != 0) &&
             cyc < 3000) begin
        pat = 2'($urandom_range(0, 3));
        run_cycle(sent < 100,
                  32'(8'h40 + 8'(sent)),
                  pat == 2'd0 || pat == 2'd3,
                  acc);
        if (acc)
          sent++;
        cyc++;
      end
      chk("t5_bound", 32'(cyc < 3000), 32'h1);
      chk("t5_rx", 32'(rx_cnt), 32'd100);
      chk("t5_first", 32'(rxq[rxq.size()-100]),
          32'h40);
      chk("t5_last", 32'(rxq[rxq.size()-1]),
          32'(8'h40 + 8'd99));
      chk("t5_empty", 32'(fifo_count), 32'h0);
    end
`else
    for (int w = 0; w < 4; w++)
      run_cycle(1'b1,
                {8'(4*w+3), 8'(4*w+2),
                 8'(4*w+1), 8'(4*w)},
                1'b0, acc);
    for (int k = 0; k < 3; k++)
      run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("t6_cnt13", 32'(fifo_count), 32'd13);
    run_cycle(1'b1, 32'hDDCCBBAA, 1'b0, acc);
    chk("t6_blocked", 32'(acc), 32'h0);
    run_cycle(1'b1, 32'hDDCCBBAA, 1'b1, acc);
    chk("t6_nobypass", 32'(acc), 32'h0);
    run_cycle(1'b1, 32'hDDCCBBAA, 1'b0, acc);
    chk("t6_accept", 32'(acc), 32'h1);
    out_issued = 1'b0;
    #1;
    chk("t6_cnt16", 32'(fifo_count), 32'd16);
    drain;
    chk("t6_rxcnt", 32'(rxq.size()), 32'd20);
    chk("t6_old", 32'(rxq[15]), 32'h0F);
    chk("t6_b0", 32'(rxq[16]), 32'hAA);
    chk("t6_b1", 32'(rxq[17]), 32'hBB);
    chk("t6_b2", 32'(rxq[18]), 32'hCC);
    chk("t6_b3", 32'(rxq[19]), 32'hDD);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
